key_encoder: RTL

KEY_ENCODER -- requirements
Module: key_encoder

---
 rtl/key_pkg.sv | 32 +++
 rtl/key_sync.sv | 25 ++
 rtl/key_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types, defaults and helpers for the key encoder
// Contents: FSM state enum, default parameter constants, one-hot encoder,
//           multi-hot detector.
package key_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_DELAY    = 16;
  localparam int unsigned DEF_REPEAT_PERIOD   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  // Only ever called on a vector already known to be one-hot.
  function automatic logic [1:0] key_encode(input logic [3:0] oh);
    logic [1:0] code;
    code = 2'd0;
    if (oh[1]) code = 2'd1;
    if (oh[2]) code = 2'd2;
    if (oh[3]) code = 2'd3;
    return code;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - 2-flop synchronizer for the 4 raw button lines
// Ports: clk, rst_n (async active-low clear), d_i raw lines, s_o synchronized.
module key_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_i,
  output logic [3:0] s_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'd0;
      sync_q <= 4'd0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign s_o = sync_q;

endmodule

// File: rtl/key_encoder.sv
// rtl/key_encoder.sv - debounced 4-button to 2-bit key code encoder
// Ports: clk, rst_n (async active-low), d raw buttons, q last accepted code,
//        valid one-cycle event pulse, busy FSM not idle, err multi-hot seen.
// Build option: KEY_REPEAT_EN adds auto-repeat pulses while a key is held.
module key_encoder
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [1:0] q,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CNT_W = $clog2(MAX_ALL) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s;
  key_state_e       state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       q_q;
  logic             valid_q;
  logic             busy_q;
  logic             err_q;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  // Set once the first repeat has fired; later repeats use the shorter period.
  logic rep_armed_q;
`endif

  key_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (d),
    .s_o   (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      q_q     <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_armed_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= is_multi_hot(s) && ((state_q == ST_IDLE) || (state_q == ST_DEBOUNCE));
      case (state_q)
        ST_IDLE: begin
          if ((s != 4'd0) && !is_multi_hot(s)) begin
            cand_q  <= s;
            cnt_q   <= '0;
            state_q <= ST_DEBOUNCE;
            busy_q  <= 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (s == cand_q) begin
            if (cnt_q == DB_LAST) begin
              state_q <= ST_HELD;
              q_q     <= key_encode(cand_q);
              valid_q <= 1'b1;
              cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
              rep_armed_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_HELD: begin
          if (s != cand_q) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_armed_q ? (cnt_q == RP_LAST) : (cnt_q == RD_LAST)) begin
            valid_q     <= 1'b1;
            cnt_q       <= '0;
            rep_armed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          // Any non-zero sample, even the old key, restarts the quiet count.
          if (s == 4'd0) begin
            if (cnt_q == DB_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
